mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result-half width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 6, iteration counter width; CNT_W SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port arst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port start  input  1  request a signed multiply of op_a by op_b; sampled only in IDLE.
REQ-006 Port op_a  input  WIDTH  multiplicand, two's complement.
REQ-007 Port op_b  input  WIDTH  multiplier, two's complement.
REQ-008 Port flush  input  1  abort the operation in progress, e.g. on pipeline flush.
REQ-009 Port busy  output  1  high while the operation is in CALC or SIGN; the pipeline stalls on it.
REQ-010 Port done  output  1  one-cycle pulse when hi/lo hold a new product.
REQ-011 Port hi  output  WIDTH  upper half of the 2*WIDTH-bit product, registered.
REQ-012 Port lo  output  WIDTH  lower half of the 2*WIDTH-bit product, registered.

Function
REQ-013 The FSM SHALL have four states: IDLE, CALC, SIGN, DONE.
REQ-014 IDLE with start=1 and flush=0 SHALL:
- latch |op_a| and |op_b|;
- latch sign = op_a[MSB] XOR op_b[MSB];
- clear the 2*WIDTH accumulator and the counter;
- go to CALC.
REQ-015 IDLE with start=0 or flush=1 SHALL stay in IDLE.
REQ-016 Each CALC cycle SHALL do one radix-2 shift-add step: if multiplier LSB=1, add the multiplicand to the accumulator upper half; shift the accumulator and multiplier right by one; increment the counter.
REQ-017 CALC SHALL go to SIGN after exactly WIDTH cycles, when counter = WIDTH-1.
REQ-018 SIGN SHALL negate the 2*WIDTH accumulator (two's complement) if sign=1, write {hi,lo}, and go to DONE.
REQ-019 DONE SHALL assert done for one cycle and return to IDLE; a start in DONE SHALL be ignored.
REQ-020 busy SHALL be 1 exactly in CALC and SIGN.
REQ-021 Latency SHALL be WIDTH+2 cycles from the start edge to the done edge (34 for WIDTH=32).
REQ-022 hi/lo SHALL change only in SIGN and SHALL hold their value at all other times, including across a flush.
REQ-023 flush in CALC or SIGN SHALL force IDLE at the next edge with no hi/lo write and no done; flush has priority over start and over the SIGN write.
REQ-024 start while busy SHALL be ignored and not queued.
REQ-025 Magnitude of the most negative operand (0x80000000) SHALL be handled as unsigned 2^(WIDTH-1), with no overflow.
REQ-026 The accumulator add SHALL be WIDTH+1 bits wide so the carry is kept.

Reset
REQ-027 When arst_n=0 the block SHALL asynchronously force: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept start on the first clock edge.

Structure
REQ-029 The shared package SHALL hold the state encoding constants (IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3) and FUNC_MULT=6'b011000, which the decoder also uses.
REQ-030 The datapath (magnitude, shift-add, final negate) SHALL be one sub-module, mult_datapath, controlled by the FSM in mult_sequencer.
REQ-031 alu_control SHALL keep its MULT_OP code; the decoder SHALL steer FUNC_MULT to this block instead of the ALU.

Verification
REQ-032 op_a=3, op_b=5, start one cycle -> busy high 33 cycles, done at cycle 34, hi=0x00000000, lo=0x0000000F.
REQ-033 op_a=-2, op_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000; also 0x7FFFFFFF*0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
REQ-035 Second start with op_a=7 at cycle 10 of a busy op -> ignored; one done only; result is from the first operands.
REQ-036 flush at cycle 20 of CALC -> IDLE next edge, busy=0, no done, hi/lo keep the previous result; a new start then completes normally.
REQ-037 arst_n low at cycle 15 of CALC -> all outputs 0 immediately; after release, 3*5 gives lo=15 in 34 cycles.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mult_sequencer_pkg
// Shared definitions for the multi-cycle signed multiplier:
//   - state_t     : FSM state encoding (IDLE, CALC, SIGN, DONE)
//   - FUNC_MULT   : function code the instruction decoder steers to this
//                   block instead of the ALU (alu_control keeps MULT_OP)
//   - state_is_busy : helper telling whether a state stalls the pipeline
// ----------------------------------------------------------------------------
package mult_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [5:0] FUNC_MULT = 6'b011000;

   // The pipeline is stalled while the product is being formed or signed.
   function automatic logic state_is_busy(input state_t st);
      logic res;
      case (st)
         CALC:    res = 1'b1;
         SIGN:    res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mult_datapath.sv
// ----------------------------------------------------------------------------
// mult_datapath
// Radix-2 shift-add magnitude multiplier with final two's-complement fixup.
// Ports:
//   clk, arst_n     : clock, asynchronous active-low reset
//   load            : capture |op_a|, |op_b| and the product sign, clear acc
//   step            : one shift-add iteration
//   write           : copy the (sign-corrected) accumulator into hi/lo
//   op_a, op_b      : signed operands
//   hi, lo          : registered upper/lower product halves
// ----------------------------------------------------------------------------
module mult_datapath
   import mult_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load,
   input  logic             step,
   input  logic             write,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [2*WIDTH-1:0] acc_r;
   logic               sign_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic [WIDTH-1:0]   mag_a_s;
   logic [WIDTH-1:0]   mag_b_s;
   logic [WIDTH:0]     addend_s;
   logic [WIDTH:0]     sum_s;
   logic [2*WIDTH-1:0] shift_s;
   logic [2*WIDTH-1:0] result_s;

   // Operand magnitudes, shift-add step and final negate.
   always_comb begin
      // The most negative value negates to itself; read as unsigned it is
      // exactly 2^(WIDTH-1), so no extra bit is needed.
      if (op_a[WIDTH-1]) begin
         mag_a_s = ~op_a + ONE_W;
      end else begin
         mag_a_s = op_a;
      end
      if (op_b[WIDTH-1]) begin
         mag_b_s = ~op_b + ONE_W;
      end else begin
         mag_b_s = op_b;
      end
      if (mplier_r[0]) begin
         addend_s = {1'b0, mcand_r};
      end else begin
         addend_s = {(WIDTH+1){1'b0}};
      end
      // WIDTH+1-bit sum keeps the carry, which shifts into the top bit.
      sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
      shift_s = {sum_s, acc_r[WIDTH-1:1]};
      if (sign_r) begin
         result_s = ~acc_r + ONE_2W;
      end else begin
         result_s = acc_r;
      end
   end

   // Operand, sign and accumulator registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
         sign_r   <= 1'b0;
      end else if (load) begin
         mcand_r  <= mag_a_s;
         mplier_r <= mag_b_s;
         acc_r    <= {(2*WIDTH){1'b0}};
         sign_r   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      end else if (step) begin
         acc_r    <= shift_s;
         mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      end else begin
         acc_r    <= acc_r;
         mplier_r <= mplier_r;
      end
   end

   // Result registers: only the write strobe updates them, so an aborted
   // operation leaves the previous product visible.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         hi_r <= {WIDTH{1'b0}};
         lo_r <= {WIDTH{1'b0}};
      end else if (write) begin
         hi_r <= result_s[2*WIDTH-1:WIDTH];
         lo_r <= result_s[WIDTH-1:0];
      end else begin
         hi_r <= hi_r;
         lo_r <= lo_r;
      end
   end

   assign hi = hi_r;
   assign lo = lo_r;

endmodule

// File: rtl/mult_sequencer.sv
// ----------------------------------------------------------------------------
// mult_sequencer
// Multi-cycle signed WIDTH x WIDTH multiplier with a 2*WIDTH-bit result.
// Latency is WIDTH+2 cycles from the start edge to the done edge.
// Ports:
//   clk, arst_n  : clock, asynchronous active-low reset
//   start        : request a multiply (sampled in IDLE only, never queued)
//   op_a, op_b   : signed operands
//   flush        : abort the operation in progress (wins over start/write)
//   busy         : high in CALC and SIGN; stalls the pipeline
//   done         : one-cycle pulse when hi/lo hold a new product
//   hi, lo       : registered product halves
// ----------------------------------------------------------------------------
module mult_sequencer
   import mult_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;

   logic             load_s;
   logic             step_s;
   logic             write_s;

   // Datapath strobes decoded from the current state; flush suppresses all.
   always_comb begin
      load_s  = 1'b0;
      step_s  = 1'b0;
      write_s = 1'b0;
      case (state_r)
         IDLE:    load_s  = start & ~flush;
         CALC:    step_s  = ~flush;
         SIGN:    write_s = ~flush;
         default: begin
            load_s  = 1'b0;
            step_s  = 1'b0;
            write_s = 1'b0;
         end
      endcase
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start && !flush) begin
                  state_r <= CALC;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= state_is_busy(CALC);
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            CALC: begin
               done_r <= 1'b0;
               if (flush) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (cnt_r == LAST_CNT) begin
                  // Last of WIDTH steps: the magnitude product is complete.
                  state_r <= SIGN;
                  cnt_r   <= cnt_r + ONE_CNT;
                  busy_r  <= state_is_busy(SIGN);
               end else begin
                  state_r <= CALC;
                  cnt_r   <= cnt_r + ONE_CNT;
                  busy_r  <= 1'b1;
               end
            end
            SIGN: begin
               busy_r <= 1'b0;
               if (flush) begin
                  state_r <= IDLE;
                  done_r  <= 1'b0;
               end else begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end
            end
            DONE: begin
               // start is deliberately not looked at here.
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CNT_W{1'b0}};
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   mult_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .arst_n (arst_n),
      .load   (load_s),
      .step   (step_s),
      .write  (write_s),
      .op_a   (op_a),
      .op_b   (op_b),
      .hi     (hi),
      .lo     (lo)
   );

   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mult_sequencer
// Table-driven self-checking bench for mult_sequencer (WIDTH=32) with a
// scoreboard queue of expected {hi,lo} products, plus hand-written
// sequences for ignored start, flush (CALC and SIGN) and mid-op reset.
// ----------------------------------------------------------------------------
module tb_mult_sequencer;

   localparam int W = 32;

   logic         clk;
   logic         arst_n;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         flush;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t        tbl [8];
   logic [63:0] sb_q [$];
   logic [63:0] last_exp;
   int          n_cmp;
   int          n_fail;

   mult_sequencer #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
   endfunction

   // Drive a one-cycle start; returns #1 after the start edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit sync);
      if (sync) @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait for done (bounded), pop the scoreboard and compare.
   task automatic finish_op(input string name, input bit chk_timing);
      int          cyc;
      int          bcnt;
      bit          got;
      logic [63:0] exp;
      cyc  = 0;
      got  = 1'b0;
      bcnt = busy ? 1 : 0;
      while (!got && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) got = 1'b1;
         else if (busy) bcnt++;
      end
      if (!got) begin
         check({name, "_timeout"}, 64'd0, 64'd1);
      end else if (sb_q.size() == 0) begin
         check({name, "_unexpected_done"}, 64'd1, 64'd0);
      end else begin
         exp      = sb_q.pop_front();
         last_exp = exp;
         check(name, {hi, lo}, exp);
         if (chk_timing) begin
            check({name, "_latency"}, 64'(cyc + 1), 64'd34);
            check({name, "_busy_cycles"}, 64'(bcnt), 64'd33);
         end
         @(posedge clk);
         #1;
         check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
      end
   endtask

   // Watch for a number of cycles and flag any done pulse.
   task automatic expect_no_done(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check(name, 64'(seen), 64'd0);
   endtask

   // Advance from #1 after the start edge to the negedge before edge k.
   task automatic to_cycle(input int k);
      for (int i = 1; i < k; i++) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      last_exp = 64'd0;
      start    = 1'b0;
      flush    = 1'b0;
      op_a     = 32'd0;
      op_b     = 32'd0;

      tbl[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
      tbl[1] = '{32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      tbl[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      tbl[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
      tbl[4] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
      tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      tbl[6] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      tbl[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

      // Reset state.
      arst_n = 1'b0;
      #12;
      check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
      check("reset_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      arst_n = 1'b1;

      // Table vectors.
      for (int i = 0; i < 8; i++) begin
         sb_q.push_back({tbl[i].exp_hi, tbl[i].exp_lo});
         launch(tbl[i].a, tbl[i].b, 1'b1);
         finish_op($sformatf("vec%0d", i), 1'b1);
      end

      // Random operands against the signed model.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = $urandom;
         sb_q.push_back(model(ra, rb));
         launch(ra, rb, 1'b1);
         finish_op($sformatf("rand%0d", i), 1'b0);
      end

      // Second start at cycle 10 is ignored; result from first operands.
      sb_q.push_back(64'd15);
      launch(32'd3, 32'd5, 1'b1);
      to_cycle(10);
      op_a  = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = 32'd3;
      finish_op("ignored_start", 1'b0);
      expect_no_done("ignored_start_single_done", 40);
      check("ignored_start_queue", 64'(sb_q.size()), 64'd0);

      // Flush at cycle 20 of CALC.
      launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      to_cycle(20);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_calc_busy_done", {62'd0, busy, done}, 64'd0);
      check("flush_calc_hold", {hi, lo}, last_exp);
      expect_no_done("flush_calc_no_done", 40);
      sb_q.push_back(model(32'hFFFF_FFF9, 32'd6));
      launch(32'hFFFF_FFF9, 32'd6, 1'b1);
      finish_op("after_flush", 1'b1);

      // Flush while in SIGN (after the last CALC edge) blocks the write.
      launch(32'd11, 32'd13, 1'b1);
      to_cycle(33);
      check("in_sign_busy", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_sign_hold", {hi, lo}, last_exp);
      expect_no_done("flush_sign_no_done", 10);

      // Reset at cycle 15 of CALC, then start on the first edge after release.
      launch(32'd100, 32'd200, 1'b1);
      to_cycle(15);
      arst_n = 1'b0;
      #1;
      check("midop_reset_outputs", {30'd0, busy, done, hi}, 64'd0);
      check("midop_reset_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      arst_n = 1'b1;
      sb_q.push_back(64'd15);
      launch(32'd3, 32'd5, 1'b0);
      finish_op("after_reset", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
